// File: rtl/nn_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nn_layer_sequencer
// Description : Drives one shared signed fixed-point MAC over a fully
//               connected layer. For every output neuron it streams inputs and
//               weights from synchronous RAMs, adds the bias, shifts back to
//               the data format, saturates, applies ReLU or identity and
//               writes the result to the output RAM.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock     in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start     in   job request, sampled only while idle
//   n_in      in   inputs per neuron (captured at start)
//   n_out     in   neuron count (captured at start)
//   w_base    in   weight RAM base address (captured at start)
//   act_sel   in   0 = ReLU, 1 = identity (captured at start)
//   in_addr   out  input RAM read address
//   in_data   in   input RAM data, one cycle after in_addr
//   w_addr    out  weight RAM read address
//   w_data    in   weight RAM data, one cycle after w_addr
//   out_addr  out  output RAM write address
//   out_data  out  output RAM write data
//   out_we    out  output RAM write enable
//   busy      out  high whenever a job is in progress (including DONE)
//   finished  out  one-cycle completion pulse
// ============================================================================
module nn_layer_sequencer #(
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int IN_AW = 8,
    parameter int W_AW  = 16,
    parameter int ACC_W = 2*DW + IN_AW + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [IN_AW-1:0] n_in,
    input  logic [IN_AW-1:0] n_out,
    input  logic [W_AW-1:0]  w_base,
    input  logic             act_sel,
    output logic [IN_AW-1:0] in_addr,
    input  logic [DW-1:0]    in_data,
    output logic [W_AW-1:0]  w_addr,
    input  logic [DW-1:0]    w_data,
    output logic [IN_AW-1:0] out_addr,
    output logic [DW-1:0]    out_data,
    output logic             out_we,
    output logic             busy,
    output logic             finished
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [DW-1:0]    c_sat_max = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]    c_sat_min = {1'b1, {(DW-1){1'b0}}};
    localparam logic [IN_AW-1:0] c_one_in  = IN_AW'(1);
    localparam logic [IN_AW:0]   c_one_jx  = (IN_AW+1)'(1);
    localparam logic [W_AW-1:0]  c_one_w   = W_AW'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                    r_state_q,   w_state_d;
    logic [IN_AW-1:0]          r_n_in_q,    w_n_in_d;
    logic [IN_AW-1:0]          r_n_out_q,   w_n_out_d;
    logic                      r_act_sel_q, w_act_sel_d;
    logic [IN_AW-1:0]          r_j_q,       w_j_d;
    logic [IN_AW-1:0]          r_k_q,       w_k_d;
    logic [W_AW-1:0]           r_wptr_q,    w_wptr_d;
    logic signed [ACC_W-1:0]   r_acc_q,     w_acc_d;
    // Read-data tags: RAM data returns one cycle after the address, so the
    // accumulate decision is delayed by one cycle alongside it.
    logic                      r_vld_q,     w_vld_d;
    logic                      r_bias_q,    w_bias_d;

    // ------------------------------------------------------------------
    // MAC terms
    // ------------------------------------------------------------------
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;

    assign w_prod     = $signed(in_data) * $signed(w_data);
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    // Bias is stored in data format; align it with the Q(2*FRAC) products.
    assign w_bias_ext = {{(ACC_W-DW-FRAC){w_data[DW-1]}}, w_data, {FRAC{1'b0}}};

    // ------------------------------------------------------------------
    // Rescale, saturate and activate
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_shift;
    logic                    w_ovf;
    logic [DW-1:0]           w_sat;
    logic [DW-1:0]           w_result;

    assign w_shift = r_acc_q >>> FRAC;
    // In range only when every bit from the DW-bit sign position upward agrees.
    assign w_ovf   = !(&w_shift[ACC_W-1:DW-1]) && (|w_shift[ACC_W-1:DW-1]);
    assign w_sat   = w_ovf ? (w_shift[ACC_W-1] ? c_sat_min : c_sat_max)
                           : w_shift[DW-1:0];
    assign w_result = (!r_act_sel_q && w_sat[DW-1]) ? '0 : w_sat;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_n_in_d    = r_n_in_q;
        w_n_out_d   = r_n_out_q;
        w_act_sel_d = r_act_sel_q;
        w_j_d       = r_j_q;
        w_k_d       = r_k_q;
        w_wptr_d    = r_wptr_q;
        w_acc_d     = r_acc_q;
        w_vld_d     = 1'b0;
        w_bias_d    = 1'b0;
        in_addr     = '0;
        w_addr      = '0;
        out_addr    = '0;
        out_data    = '0;
        out_we      = 1'b0;
        busy        = 1'b0;
        finished    = 1'b0;

        // Consume the data requested in the previous cycle.
        if (r_vld_q) begin
            w_acc_d = r_acc_q + (r_bias_q ? w_bias_ext : w_prod_ext);
        end

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_n_in_d    = n_in;
                    w_n_out_d   = n_out;
                    w_act_sel_d = act_sel;
                    w_j_d       = '0;
                    w_k_d       = '0;
                    w_wptr_d    = w_base;
                    w_acc_d     = '0;
                    w_state_d   = (n_out == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                busy     = 1'b1;
                w_addr   = r_wptr_q + W_AW'(r_k_q);
                w_vld_d  = 1'b1;
                w_bias_d = (r_k_q == r_n_in_q);
                // On the bias cycle the input address parks on the last input.
                if (r_k_q < r_n_in_q) begin
                    in_addr = r_k_q;
                end else if (r_n_in_q != '0) begin
                    in_addr = r_n_in_q - c_one_in;
                end
                if (r_k_q == r_n_in_q) begin
                    w_state_d = ST_DRAIN;
                end else begin
                    w_k_d = r_k_q + c_one_in;
                end
            end

            ST_DRAIN: begin
                busy      = 1'b1;
                w_state_d = ST_WRITE;
            end

            ST_WRITE: begin
                busy     = 1'b1;
                out_we   = 1'b1;
                out_addr = r_j_q;
                out_data = w_result;
                w_acc_d  = '0;
                w_k_d    = '0;
                w_j_d    = r_j_q + c_one_in;
                // Rows are n_in weights followed by one bias.
                w_wptr_d = r_wptr_q + W_AW'(r_n_in_q) + c_one_w;
                if (({1'b0, r_j_q} + c_one_jx) < {1'b0, r_n_out_q}) begin
                    w_state_d = ST_RUN;
                end else begin
                    w_state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy      = 1'b1;
                finished  = 1'b1;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state_q   <= ST_IDLE;
            r_n_in_q    <= '0;
            r_n_out_q   <= '0;
            r_act_sel_q <= 1'b0;
            r_j_q       <= '0;
            r_k_q       <= '0;
            r_wptr_q    <= '0;
            r_acc_q     <= '0;
            r_vld_q     <= 1'b0;
            r_bias_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_n_in_q    <= w_n_in_d;
            r_n_out_q   <= w_n_out_d;
            r_act_sel_q <= w_act_sel_d;
            r_j_q       <= w_j_d;
            r_k_q       <= w_k_d;
            r_wptr_q    <= w_wptr_d;
            r_acc_q     <= w_acc_d;
            r_vld_q     <= w_vld_d;
            r_bias_q    <= w_bias_d;
        end
    end

endmodule
`default_nettype wire
